// File: rtl/uart_matrix_engine.sv
// uart_matrix_engine: streams an N x N little-endian matrix from UART RX, accumulates trace (and row sums), emits results on TX.
//   clock/reset   : rising-edge clock, synchronous active-low reset
//   io_rx_valid/io_rx_data : received byte strobe, no backpressure
//   io_tx_valid/io_tx_data/io_tx_ready : result byte handshake, LSB first per word
//   io_clear      : synchronous abort back to RECV, clears io_overrun
//   io_busy/io_done/io_overrun : SEND state, last-byte-accepted pulse, sticky dropped-byte flag
//   Define UART_MATRIX_ROWSUM_EN to add per-row sums after the trace word.
module uart_matrix_engine #(
  parameter int N = 2,
  parameter int ELEM_BYTES = 1,
  parameter int RES_BYTES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_rx_valid,
  input  logic [7:0] io_rx_data,
  output logic       io_tx_valid,
  output logic [7:0] io_tx_data,
  input  logic       io_tx_ready,
  input  logic       io_clear,
  output logic       io_busy,
  output logic       io_done,
  output logic       io_overrun
);
  localparam int EW = 8 * ELEM_BYTES;
  localparam int AW = 8 * RES_BYTES;
`ifdef UART_MATRIX_ROWSUM_EN
  localparam int NW = N + 1;
`else
  localparam int NW = 1;
`endif
  typedef enum logic {RECV, SEND} state_t;
  state_t state, state_n;
  logic [1:0] byte_cnt, res_byte;
  logic [4:0] col, row, diag, word;
  logic [EW-1:0] elem_buf, elem_next;
  logic [AW-1:0] elem_ext, trace, out_word;
  logic rx_take, elem_done, mat_done, tx_fire, last_fire;
`ifdef UART_MATRIX_ROWSUM_EN
  logic [AW-1:0] rowsum [N];
`endif
  // Bytes enter at the top and shift down, so after ELEM_BYTES bytes byte 0 sits at bit 0.
  // diag counts modulo N+1 so a diagonal element is flagged without a divider.
  always_comb begin
    rx_take = state == RECV && io_rx_valid;
    elem_next = (elem_buf >> 8) | (EW'(io_rx_data) << (EW - 8));
    elem_ext = AW'(elem_next);
    elem_done = rx_take && byte_cnt == 2'(ELEM_BYTES - 1);
    mat_done = elem_done && row == 5'(N - 1) && col == 5'(N - 1);
    tx_fire = state == SEND && io_tx_ready;
    last_fire = tx_fire && res_byte == 2'(RES_BYTES - 1) && word == 5'(NW - 1);
    state_n = mat_done ? SEND : last_fire ? RECV : state;
    out_word = trace;
`ifdef UART_MATRIX_ROWSUM_EN
    for (int i = 0; i < N; i++) if (word == 5'(i + 1)) out_word = rowsum[i];
`endif
    io_busy = state == SEND;
    io_tx_valid = io_busy;
    io_tx_data = io_busy ? 8'(out_word >> {res_byte, 3'b000}) : 8'h00;
  end
  always_ff @(posedge clock)
    if (!reset || io_clear) state <= RECV;
    else state <= state_n;
  always_ff @(posedge clock) begin
    if (!reset || io_clear) begin
      byte_cnt <= 2'd0;
      res_byte <= 2'd0;
      col <= 5'd0;
      row <= 5'd0;
      diag <= 5'd0;
      word <= 5'd0;
      elem_buf <= '0;
      trace <= '0;
      io_done <= 1'b0;
      io_overrun <= 1'b0;
`ifdef UART_MATRIX_ROWSUM_EN
      for (int i = 0; i < N; i++) rowsum[i] <= '0;
`endif
    end else begin
      io_done <= last_fire;
      if (state == SEND && io_rx_valid) io_overrun <= 1'b1;
      if (rx_take) begin
        elem_buf <= elem_next;
        byte_cnt <= elem_done ? 2'd0 : byte_cnt + 2'd1;
      end
      if (elem_done) begin
        col <= col == 5'(N - 1) ? 5'd0 : col + 5'd1;
        row <= mat_done ? 5'd0 : col == 5'(N - 1) ? row + 5'd1 : row;
        diag <= (mat_done || diag == 5'(N)) ? 5'd0 : diag + 5'd1;
        if (diag == 5'd0) trace <= trace + elem_ext;
`ifdef UART_MATRIX_ROWSUM_EN
        for (int i = 0; i < N; i++) if (row == 5'(i)) rowsum[i] <= rowsum[i] + elem_ext;
`endif
      end
      if (tx_fire) begin
        res_byte <= res_byte == 2'(RES_BYTES - 1) ? 2'd0 : res_byte + 2'd1;
        if (res_byte == 2'(RES_BYTES - 1)) word <= last_fire ? 5'd0 : word + 5'd1;
      end
      if (last_fire) begin
        trace <= '0;
`ifdef UART_MATRIX_ROWSUM_EN
        for (int i = 0; i < N; i++) rowsum[i] <= '0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_uart_matrix_engine.sv
// tb_uart_matrix_engine: directed scoreboard bench for uart_matrix_engine in two element/result widths.
module tb_uart_matrix_engine;
  logic clock = 1'b0, reset = 1'b0, rxv = 1'b0, ready = 1'b1, clear = 1'b0, sel = 1'b0;
  logic [7:0] rxd = 8'h00;
  logic txv0, busy0, done0, ovr0, txv1, busy1, done1, ovr1;
  logic [7:0] txd0, txd1;
  logic txv, busy, done, ovr;
  logic [7:0] txd;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  always #5 clock = ~clock;
  assign txv = sel ? txv1 : txv0;
  assign txd = sel ? txd1 : txd0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign ovr = sel ? ovr1 : ovr0;
  uart_matrix_engine #(.N(2), .ELEM_BYTES(1), .RES_BYTES(4)) u0 (
    .clock(clock), .reset(reset), .io_rx_valid(rxv), .io_rx_data(rxd),
    .io_tx_valid(txv0), .io_tx_data(txd0), .io_tx_ready(ready), .io_clear(clear),
    .io_busy(busy0), .io_done(done0), .io_overrun(ovr0));
  uart_matrix_engine #(.N(2), .ELEM_BYTES(2), .RES_BYTES(1)) u1 (
    .clock(clock), .reset(reset), .io_rx_valid(rxv), .io_rx_data(rxd),
    .io_tx_valid(txv1), .io_tx_data(txd1), .io_tx_ready(ready), .io_clear(clear),
    .io_busy(busy1), .io_done(done1), .io_overrun(ovr1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic rx(input logic [7:0] b);
    rxv = 1'b1;
    rxd = b;
    @(negedge clock);
    rxv = 1'b0;
  endtask
  task automatic push_word(input logic [31:0] w, input int rb);
    for (int k = 0; k < rb; k++) q.push_back(8'(w >> (8 * k)));
  endtask
  // Model: pushes the expected result bytes, then sends the elements LSB first, back to back.
  task automatic mat(input int e[4]);
    int eb, rb;
    logic [31:0] m;
    eb = sel ? 2 : 1;
    rb = sel ? 1 : 4;
    m = rb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * rb)) - 32'd1;
    push_word(32'(e[0] + e[3]) & m, rb);
`ifdef UART_MATRIX_ROWSUM_EN
    push_word(32'(e[0] + e[1]) & m, rb);
    push_word(32'(e[2] + e[3]) & m, rb);
`endif
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < eb; k++) rx(8'(e[i] >> (8 * k)));
  endtask
  task automatic drain(input string tag);
    int n;
    while (q.size() > 0) begin
      n = 0;
      while (!(txv && ready) && n < 50) begin
        @(negedge clock);
        n++;
      end
      chk({tag, "_valid"}, {31'd0, txv}, 32'd1);
      if (!txv) begin
        q.delete();
        break;
      end
      chk({tag, "_byte"}, {24'd0, txd}, {24'd0, q.pop_front()});
      @(negedge clock);
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_off"}, {31'd0, txv}, 32'd0);
  endtask
  initial begin
    int seen;
    repeat (2) @(negedge clock);
    chk("rst_valid", {31'd0, txv}, 32'd0);
    chk("rst_data", {24'd0, txd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_overrun", {31'd0, ovr}, 32'd0);
    reset = 1'b1;
    mat('{1, 2, 3, 4});
    chk("lat_valid", {31'd0, txv}, 32'd1);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    drain("basic");
    chk("basic_overrun", {31'd0, ovr}, 32'd0);
    @(negedge clock);
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    ready = 1'b0;
    mat('{1, 2, 3, 4});
    repeat (10) begin
      chk("bp_valid", {31'd0, txv}, 32'd1);
      chk("bp_hold", {24'd0, txd}, {24'd0, q[0]});
      @(negedge clock);
    end
    ready = 1'b1;
    drain("bp");
    mat('{2, 0, 0, 2});
    drain("done_cycle_rx");
    @(negedge clock);
    ready = 1'b0;
    mat('{1, 2, 3, 4});
    rx(8'hAA);
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    chk("ovr_busy", {31'd0, busy}, 32'd1);
    chk("ovr_hold", {24'd0, txd}, {24'd0, q[0]});
    ready = 1'b1;
    drain("ovr");
    mat('{2, 0, 0, 2});
    drain("ovr_next");
    chk("ovr_sticky", {31'd0, ovr}, 32'd1);
    clear = 1'b1;
    rxv = 1'b1;
    rxd = 8'h55;
    @(negedge clock);
    clear = 1'b0;
    rxv = 1'b0;
    chk("clr_overrun", {31'd0, ovr}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd0);
    mat('{1, 2, 3, 4});
    drain("clr_rx_dropped");
    @(negedge clock);
    rx(8'h09);
    rx(8'h09);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    mat('{1, 2, 3, 4});
    drain("rst_recv");
    @(negedge clock);
    ready = 1'b0;
    mat('{1, 2, 3, 4});
    q.delete();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("rst_send_valid", {31'd0, txv}, 32'd0);
    ready = 1'b1;
    seen = 0;
    repeat (8) begin
      if (txv) seen = 1;
      @(negedge clock);
    end
    chk("rst_send_silent", 32'(seen), 32'd0);
    sel = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("wide_rst_valid", {31'd0, txv}, 32'd0);
    mat('{32'h00FF, 0, 0, 2});
    chk("wide_lat_valid", {31'd0, txv}, 32'd1);
    drain("wide_wrap");
    @(negedge clock);
    mat('{32'h1234, 7, 9, 32'h0F0F});
    drain("wide_mix");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
